// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - multi-digit BCD up/down counter with load, wrap/saturate and cascade tc
module bcd_updown_counter #(
   parameter int DIGITS = 4,
   parameter bit WRAP   = 1'b1
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                en,
   input  logic                up,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_val,
   output logic [4*DIGITS-1:0] count,
   output logic                tc,
   output logic                rollover,
   output logic                load_err
);

   logic [4*DIGITS-1:0] stepped;
   logic                at_limit;
   logic                load_ok;

   // Ripple carry/borrow digit by digit; the carry out of the top digit means
   // every digit sat at its limit, i.e. the whole count is 99..9 (up) or 00..0 (down).
   always_comb begin
      logic       carry;
      logic [3:0] dig;
      carry   = 1'b1;
      dig     = 4'd0;
      stepped = count;
      for (int d = 0; d < DIGITS; d++) begin
         dig = count[4*d +: 4];
         if (carry) begin
            if (up) begin
               stepped[4*d +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
            end else begin
               stepped[4*d +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
            end
         end
         carry = carry & (up ? (dig == 4'd9) : (dig == 4'd0));
      end
      at_limit = carry;
   end

   always_comb begin
      load_ok = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
         if (load_val[4*d +: 4] > 4'd9) begin
            load_ok = 1'b0;
         end
      end
   end

   assign tc = en & ~load & at_limit;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         count    <= '0;
         rollover <= 1'b0;
         load_err <= 1'b0;
      end else if (load) begin
         rollover <= 1'b0;
         if (load_ok) begin
            count    <= load_val;
            load_err <= 1'b0;
         end else begin
            load_err <= 1'b1;
         end
      end else if (en) begin
         load_err <= 1'b0;
         rollover <= at_limit;
         if (WRAP || !at_limit) begin
            count <= stepped;
         end
      end else begin
         rollover <= 1'b0;
         load_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - bench for bcd_updown_counter (wrap, saturate, cascaded pair)
module tb_bcd_updown_counter;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       en = 1'b0;
   logic       up = 1'b0;
   logic       load = 1'b0;
   logic       c_load = 1'b0;
   logic [7:0] load_val = 8'h00;

   logic [7:0] count_w, count_s;
   logic       tc_w, tc_s, roll_w, roll_s, lerr_w, lerr_s;
   logic [3:0] count_lo, count_hi;
   logic       tc_lo, tc_hi, roll_lo, roll_hi, lerr_lo, lerr_hi;

   int checks = 0;
   int errors = 0;
   int vw = 0, vs = 0, vc = 0;
   bit rw = 0, rs = 0, lew = 0, les = 0;
   bit primed = 0;

   always #5 clk = ~clk;

   bcd_updown_counter #(.DIGITS(2), .WRAP(1'b1)) u_wrap (
      .clk(clk), .rstn(rstn), .en(en), .up(up), .load(load), .load_val(load_val),
      .count(count_w), .tc(tc_w), .rollover(roll_w), .load_err(lerr_w));

   bcd_updown_counter #(.DIGITS(2), .WRAP(1'b0)) u_sat (
      .clk(clk), .rstn(rstn), .en(en), .up(up), .load(load), .load_val(load_val),
      .count(count_s), .tc(tc_s), .rollover(roll_s), .load_err(lerr_s));

   bcd_updown_counter #(.DIGITS(1), .WRAP(1'b1)) u_lo (
      .clk(clk), .rstn(rstn), .en(en), .up(up), .load(c_load), .load_val(load_val[3:0]),
      .count(count_lo), .tc(tc_lo), .rollover(roll_lo), .load_err(lerr_lo));

   bcd_updown_counter #(.DIGITS(1), .WRAP(1'b1)) u_hi (
      .clk(clk), .rstn(rstn), .en(tc_lo), .up(up), .load(c_load), .load_val(load_val[7:4]),
      .count(count_hi), .tc(tc_hi), .rollover(roll_hi), .load_err(lerr_hi));

   function automatic bit bcd_valid(input logic [7:0] b);
      return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
   endfunction

   function automatic int bcd2int(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic logic [7:0] int2bcd(input int v);
      logic [3:0] hi, lo;
      hi = 4'(v / 10);
      lo = 4'(v % 10);
      return {hi, lo};
   endfunction

   // Value-level counter step over 0..99.
   function automatic int next_val(input int v, input bit u, input bit wrap, output bit roll);
      roll = 1'b0;
      if (u) begin
         if (v == 99) begin roll = 1'b1; return wrap ? 0 : 99; end
         return v + 1;
      end
      if (v == 0) begin roll = 1'b1; return wrap ? 99 : 0; end
      return v - 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input bit e, input bit u, input bit l, input logic [7:0] lv);
      bit dummy;
      en = e; up = u; load = l; load_val = lv;
      c_load = l && bcd_valid(lv);
      #1;
      if (primed) begin
         chk("tc_wrap", 32'(tc_w), 32'(e && !l && (u ? vw == 99 : vw == 0)));
         chk("tc_sat",  32'(tc_s), 32'(e && !l && (u ? vs == 99 : vs == 0)));
         chk("tc_casc", 32'(tc_hi), 32'(e && !c_load && (u ? vc == 99 : vc == 0)));
      end
      @(posedge clk);
      if (!rstn) begin
         vw = 0; vs = 0; vc = 0; rw = 0; rs = 0; lew = 0; les = 0;
      end else begin
         if (l) begin
            rw = 0; rs = 0;
            if (bcd_valid(lv)) begin vw = bcd2int(lv); vs = vw; lew = 0; end
            else lew = 1;
            les = lew;
         end else if (e) begin
            vw = next_val(vw, u, 1'b1, rw);
            vs = next_val(vs, u, 1'b0, rs);
            lew = 0; les = 0;
         end else begin
            rw = 0; rs = 0; lew = 0; les = 0;
         end
         if (c_load) vc = bcd2int(lv);
         else if (e) vc = next_val(vc, u, 1'b1, dummy);
      end
      @(negedge clk);
      primed = 1'b1;
      chk("count_wrap", 32'(count_w), 32'(int2bcd(vw)));
      chk("roll_wrap",  32'(roll_w),  32'(rw));
      chk("lerr_wrap",  32'(lerr_w),  32'(lew));
      chk("count_sat",  32'(count_s), 32'(int2bcd(vs)));
      chk("roll_sat",   32'(roll_s),  32'(rs));
      chk("lerr_sat",   32'(lerr_s),  32'(les));
      chk("count_casc", 32'({count_hi, count_lo}), 32'(int2bcd(vc)));
   endtask

   initial begin
      bit e, u, l;
      logic [7:0] lv;
      // reset state, and tc while held in reset
      rstn = 1'b0;
      cycle(0, 0, 0, 8'h00);
      cycle(1, 0, 0, 8'h00);
      rstn = 1'b1;
      // up through the full range and wrap
      repeat (100) cycle(1, 1, 0, 8'h00);
      // down from 00, through 90 -> 89
      cycle(0, 0, 1, 8'h00);
      repeat (11) cycle(1, 0, 0, 8'h00);
      // saturation at both limits
      cycle(0, 1, 1, 8'h99);
      repeat (3) cycle(1, 1, 0, 8'h00);
      cycle(0, 0, 1, 8'h00);
      repeat (3) cycle(1, 0, 0, 8'h00);
      // load validation and load-over-enable priority
      cycle(0, 0, 1, 8'h3A);
      cycle(0, 0, 1, 8'h47);
      cycle(1, 1, 1, 8'h12);
      cycle(1, 1, 1, 8'h99);
      cycle(0, 0, 1, 8'hA0);
      // reset mid-count, then resume
      cycle(0, 0, 1, 8'h57);
      rstn = 1'b0;
      cycle(1, 1, 0, 8'h00);
      rstn = 1'b1;
      cycle(1, 1, 0, 8'h00);
      // randomized traffic
      repeat (500) begin
         rstn = ($urandom_range(0, 59) != 0);
         e = ($urandom_range(0, 3) != 0);
         u = 1'($urandom);
         l = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 1) == 0)
            lv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         else
            lv = 8'($urandom);
         cycle(e, u, l, lv);
      end
      rstn = 1'b1;
      repeat (120) cycle(1, 0, 0, 8'h00);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
